// File: rtl/main_fsm.sv
// ----------------------------------------------------------------------------
// main_fsm -- multicycle RISC-V main control FSM (Moore style)
//
// This FSM sequences each instruction through fetch, decode, execute,
// memory and writeback states. The datapath controls depend only on the
// current state. The only live inputs that reach the outputs are the
// qualifiers MemReady and Zero, and reset, which blanks the write enables.
// There is no combinational path from op to any output.
//
// Ports
//   clk        in   1  sole clock, rising edge
//   reset      in   1  synchronous, active-high; forces FETCH
//   op         in   7  opcode field of the instruction register
//   Zero       in   1  ALU zero flag (BEQ only)
//   MemReady   in   1  memory access completes this cycle
//   AdrSrc     out  1  0 = PC, 1 = ALU result register
//   IRWrite    out  1  instruction register load enable
//   ALUSrcA    out  2  00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB    out  2  00 = rs2, 01 = imm, 10 = const 4
//   ALUOp      out  2  00 = add, 01 = sub, 10 = funct-decoded
//   ResultSrc  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
//   RegWrite   out  1  register file write enable
//   MemWrite   out  1  memory write enable
//   PCWrite    out  1  PC write enable
// ----------------------------------------------------------------------------
module main_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       PCWrite
);

   // Opcodes
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_RTYP = 7'b0110011;
   localparam logic [6:0] OP_ITYP = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   // Mux select encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FN   = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   state_t state_q, state_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:    if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            unique case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_EXECUTER;
               OP_ITYP:      state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               // An illegal opcode goes straight back to fetch. DECODE asserts
               // no enables, so nothing is written on this path.
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (MemReady) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // Output decode: state-only selects, plus the MemReady and Zero qualifiers
   // on the enables.
   always_comb begin
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ALUOp     = ALUOP_ADD;
      ResultSrc = RES_ALUOUT;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      PCWrite   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            // Load IR and bump PC only on the cycle the fetch completes.
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_MEM;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            // Leaving on MemReady ensures exactly one write pulse per store.
            MemWrite = MemReady;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_FN;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FN;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_SUB;
            PCWrite = Zero;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      // Reset blanks every write enable so an aborted instruction cannot commit.
      if (reset) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; forces state to FETCH.
REQ-005 op  input  7  opcode field of the instruction register.
REQ-006 Zero  input  1  ALU zero flag, used only in BEQ.
REQ-007 MemReady  input  1  memory access completes this cycle.
REQ-008 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 IRWrite  output  1  instruction register load enable.
REQ-010 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-011 ALUSrcB  output  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
REQ-012 ALUOp  output  2  control to aludec: 00 = add, 01 = sub, 10 = funct-decoded.
REQ-013 ResultSrc  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
REQ-014 RegWrite, MemWrite, PCWrite  output  1 each  register file, memory and PC write enables.

Function
REQ-015 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Output qualifiers: MemReady gates the FETCH, MEMREAD and MEMWRITE enables; Zero gates PCWrite in BEQ.
REQ-016 FETCH outputs SHALL be AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- IRWrite=PCWrite=MemReady.
- Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
REQ-017 DECODE outputs SHALL be ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
- Any other op -> FETCH; no write enable is asserted on that path.
REQ-018 MEMADR outputs SHALL be ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- Next state: op=0000011 -> MEMREAD; otherwise -> MEMWRITE.
REQ-019 MEMREAD outputs SHALL be AdrSrc=1, ResultSrc=00.
- Hold while MemReady=0; go to MEMWB when MemReady=1.
REQ-020 MEMWB outputs SHALL be ResultSrc=01, RegWrite=1; next state FETCH.
REQ-021 MEMWRITE outputs SHALL be AdrSrc=1, ResultSrc=00, MemWrite=MemReady.
- Hold while MemReady=0; go to FETCH when MemReady=1.
- MemWrite SHALL be high for exactly one cycle per store.
REQ-022 EXECUTER outputs SHALL be ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-023 EXECUTEI outputs SHALL be ALUSrcA=10, ALUSrcB=01, ALUOp=10; next state ALUWB.
REQ-024 ALUWB outputs SHALL be ResultSrc=00, RegWrite=1; next state FETCH.
REQ-025 BEQ outputs SHALL be ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero; next state FETCH.
REQ-026 JAL outputs SHALL be ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next state ALUWB.
REQ-027 Every output not listed for a state SHALL be 0.
REQ-028 The outputs SHALL have no combinational path from op to any output.
REQ-029 Instruction latency with MemReady held at 1 SHALL be:
- lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
- Each extra cycle with MemReady=0 adds one cycle.

Reset
REQ-030 While reset=1 at a rising edge, the next state SHALL be FETCH, regardless of the current state or MemReady.
REQ-031 While reset is high, IRWrite, PCWrite, RegWrite and MemWrite SHALL be forced to 0.
REQ-032 A reset asserted mid-instruction (e.g. in MEMWRITE with MemReady=0) SHALL abort that instruction with no further write enable.
REQ-033 The first fetch SHALL begin in the cycle after reset deasserts.

Verification
REQ-034 lw: reset, then op=0000011, MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5.
REQ-035 sw with wait: op=0100011, MemReady=0 for 2 cycles in MEMWRITE -> MemWrite=0 for 2 cycles, then 1 for one cycle, then FETCH.
REQ-036 beq: op=1100011, Zero=1 -> PCWrite=1 and ALUOp=01 in cycle 3; with Zero=0, PCWrite=0 in cycle 3; both return to FETCH.
REQ-037 R-type then jal: op=0110011 gives ALUOp=10, ALUSrcB=00 in EXECUTER; op=1101111 gives PCWrite=1 in JAL, then RegWrite=1 in ALUWB.
REQ-038 Illegal opcode: op=1111111 in DECODE -> FETCH next cycle, with RegWrite=MemWrite=PCWrite=0 throughout.
REQ-039 Reset mid-op: assert reset in EXECUTEI -> FETCH next cycle, no RegWrite pulse; fetch stalls while MemReady=0 (IRWrite=0).
